uc_seq_ctrl: RTL and testbench
==============================

// Module: uc_seq_ctrl
// PURPOSE
//  Sequencer directly upstream of the universal counter (uc_beh). Turns a one-shot
//  start command into the counter's load/en/up_down/data controls, watches the
//  counter output q, stops it exactly on the target value, and reports done/err.
//  Supports single up-sweep, single down-sweep and repeated up/down ping-pong.
// PARAMETERS
//  W        4  counter width; matches uc_beh data/q width
//  SWEEP_W  4  width of the ping-pong sweep-count input
// PORTS
//  clk      in   1        single clock, rising edge
//  clr      in   1        reset: asynchronous, active-high
//  start    in   1        command strobe; sampled only in IDLE
//  mode     in   2        00 up, 01 down, 10 ping-pong, 11 reserved
//  preset   in   W        start value loaded into counter
//  limit    in   W        target value (turn-around value for ping-pong)
//  sweeps   in   SWEEP_W  ping-pong sweep count; 0 treated as 1
//  abort    in   1        cancel current sequence
//  q_in     in   W        counter output q (feedback)
//  load     out  1        -> counter load
//  data     out  W        -> counter data (= latched preset)
//  en       out  1        -> counter en
//  up_down  out  1        -> counter up_down (1 = up)
//  busy     out  1        high in any state other than IDLE
//  done     out  1        one-cycle pulse on normal completion
//  err      out  1        one-cycle pulse on rejected command
// BEHAVIOUR
//  - clr async: state IDLE, latched regs 0; load=0 en=0 up_down=1 data=0 busy=0 done=0 err=0.
//  - States: IDLE, LOAD, RUN_UP, RUN_DN, DONE. Outputs decoded from state (+ q_in for en).
//  - IDLE: start=1 latches mode/preset/limit/sweeps. Reject (err=1 next cycle, stay IDLE) if
//    mode=11, mode 00/10 with preset>limit, or mode 01 with preset<limit; else -> LOAD.
//  - LOAD (1 cycle): load=1, data=preset, en=0. -> RUN_DN if mode 01, else RUN_UP.
//  - RUN_UP: up_down=1, target=limit. RUN_DN: up_down=0, target=preset (ping-pong) or limit (mode 01).
//    en = (q_in != target), combinational from q_in, so counter halts exactly on target.
//    When q_in == target: RUN_UP -> RUN_DN (mode 10) or DONE; RUN_DN -> DONE (mode 01);
//    mode 10 in RUN_DN: decrement sweep count; -> RUN_UP if remaining, else DONE.
//  - DONE (1 cycle): done=1, en=0 -> IDLE.
//  - Latency (start-sampling edge = edge 0): done high after edge 1+|limit-preset|+1 for
//    modes 00/01; after edge 1+S*(2*(limit-preset)+2) for ping-pong, S=max(sweeps,1).
//  - preset==limit: run state sees target immediately, en stays 0, completes normally.
//  - abort in any non-IDLE state: load=0 en=0 combinationally that cycle, -> IDLE next edge;
//    no done, no err. abort in IDLE ignored. abort beats start/target in same cycle.
//  - start while busy ignored; inputs other than q_in/abort are not re-sampled while busy.
//  - No wrap-around: counter never passes target; comparisons are unsigned W-bit.
//  - clr mid-sequence: immediate return to reset values; counter cleared by same clr.
// STRUCTURE
//  - uc_pkg: state encoding localparams (S_IDLE..S_DONE), mode codes (M_UP, M_DN, M_PP, M_RSVD).
//  - Single module: FSM, latch regs (mode/preset/limit), SWEEP_W sweep down-counter.
//    No sub-module; bench instantiates uc_seq_ctrl + uc_beh wired back-to-back.
// TESTING
//  1 clr=1 then release, no start -> all outputs at reset values, q=0, busy=0.
//  2 mode=00 preset=2 limit=5 -> load 1 cycle, q 2,3,4,5, en low at q=5, done 5 edges after start.
//  3 mode=01 preset=9 limit=3 -> q counts 9..3 with up_down=0, halts at 3, one done pulse.
//  4 mode=10 preset=1 limit=3 sweeps=2 -> q 1,2,3,3,2,1,1,2,3,3,2,1; done after edge 13.
//  5 mode=00 preset=7 limit=4, then mode=11 -> err pulse each, busy stays 0, counter untouched.
//  6 mode=10 running, abort at q=2 -> en=0 same cycle, IDLE next, q holds 2, no done;
//    repeat with clr mid-run -> immediate reset values.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared definitions for the universal-counter sequencer: FSM states, mode codes
// and the command acceptance rule.
package uc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN_UP = 3'd2,
    S_RUN_DN = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DN   = 2'b01;
  localparam logic [1:0] M_PP   = 2'b10;
  localparam logic [1:0] M_RSVD = 2'b11;

  // Up and ping-pong need preset <= limit; down needs preset >= limit.
  function automatic logic cmd_ok(input logic [1:0] m, input logic p_gt_l, input logic p_lt_l);
    case (m)
      M_UP, M_PP: cmd_ok = ~p_gt_l;
      M_DN:       cmd_ok = ~p_lt_l;
      default:    cmd_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uc_seq_ctrl.sv
// Sequencer in front of the universal counter: loads the preset, steers count
// direction, stops the counter exactly on target and reports done/err.
module uc_seq_ctrl
  import uc_pkg::*;
#(
  parameter int W       = 4,
  parameter int SWEEP_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [W-1:0]       preset,
  input  logic [W-1:0]       limit,
  input  logic [SWEEP_W-1:0] sweeps,
  input  logic               abort,
  input  logic [W-1:0]       q_in,
  output logic               load,
  output logic [W-1:0]       data,
  output logic               en,
  output logic               up_down,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [W-1:0]       preset_q, preset_d;
  logic [W-1:0]       limit_q, limit_d;
  logic [SWEEP_W-1:0] sweep_q, sweep_d;
  logic               err_q, err_d;

  logic [W-1:0] target;
  logic         at_target;
  logic         running;
  logic         abort_act;

  // Only the ping-pong down leg returns to the preset; every other leg runs to limit.
  assign target    = (state_q == S_RUN_DN && mode_q == M_PP) ? preset_q : limit_q;
  assign at_target = (q_in == target);
  assign running   = (state_q == S_RUN_UP) || (state_q == S_RUN_DN);
  assign abort_act = abort && (state_q != S_IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      preset_q <= '0;
      limit_q  <= '0;
      sweep_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      preset_q <= preset_d;
      limit_q  <= limit_d;
      sweep_q  <= sweep_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    preset_d = preset_q;
    limit_d  = limit_q;
    sweep_d  = sweep_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          preset_d = preset;
          limit_d  = limit;
          sweep_d  = (sweeps == '0) ? SWEEP_W'(1) : sweeps;
          if (cmd_ok(mode, preset > limit, preset < limit)) state_d = S_LOAD;
          else                                              err_d   = 1'b1;
        end
      end
      S_LOAD:   state_d = (mode_q == M_DN) ? S_RUN_DN : S_RUN_UP;
      S_RUN_UP: if (at_target) state_d = (mode_q == M_PP) ? S_RUN_DN : S_DONE;
      S_RUN_DN: begin
        if (at_target) begin
          if (mode_q == M_PP && sweep_q > SWEEP_W'(1)) begin
            sweep_d = sweep_q - SWEEP_W'(1);
            state_d = S_RUN_UP;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_act) state_d = S_IDLE;
  end

  // en follows q_in combinationally so the counter freezes on the target edge itself.
  always_comb begin
    load    = (state_q == S_LOAD) && !abort_act;
    en      = running && !at_target && !abort_act;
    up_down = (state_q != S_RUN_DN);
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE) && !abort_act;
    err     = err_q;
    data    = preset_q;
  end

endmodule

// File: tb/tb_uc_seq_ctrl.sv
// Bench: sequencer driving a behavioural up/down counter, checked against an
// expected q trace built directly from the sweep rules.
module tb_uc_seq_ctrl;

  localparam int W  = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          clr, start, abort;
  logic [1:0]    mode;
  logic [W-1:0]  preset, limit, q_cnt, data;
  logic [SW-1:0] sweeps;
  logic          load, en, up_down, busy, done, err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Universal counter stand-in: load beats count, async clear shares clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)       q_cnt <= '0;
    else if (load) q_cnt <= data;
    else if (en)   q_cnt <= up_down ? q_cnt + 1'b1 : q_cnt - 1'b1;
  end

  uc_seq_ctrl #(.W(W), .SWEEP_W(SW)) dut (
    .clk(clk), .clr(clr), .start(start), .mode(mode), .preset(preset),
    .limit(limit), .sweeps(sweeps), .abort(abort), .q_in(q_cnt),
    .load(load), .data(data), .en(en), .up_down(up_down),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // abort_k / clr_k: cycle (after edge k) at which to abort or clear; out of range = never.
  task automatic run_txn(input int m, input int p, input int l, input int s,
                         input int abort_k, input int clr_k);
    int  trace[$];
    int  d, sw;
    bit  rej;
    logic [W-1:0] q0;
    q0  = q_cnt;
    rej = (m == 3) || (m != 1 && p > l) || (m == 1 && p < l);
    mode = 2'(m); preset = W'(p); limit = W'(l); sweeps = SW'(s); start = 1'b1;
    step();
    start = 1'b0;
    mode = 2'($urandom_range(0, 3)); preset = W'($urandom_range(0, 15));
    limit = W'($urandom_range(0, 15)); sweeps = SW'($urandom_range(0, 15));
    if (rej) begin
      chk("rej_err", err, 1);
      chk("rej_busy", busy, 0);
      step();
      chk("rej_err_drop", err, 0);
      chk("rej_busy2", busy, 0);
      chk("rej_q", q_cnt, q0);
      $display("txn mode=%0d preset=%0d limit=%0d sweeps=%0d rejected", m, p, l, s);
      return;
    end
    chk("load_pulse", load, 1);
    chk("load_en", en, 0);
    chk("load_busy", busy, 1);
    chk("load_data", data, p);
    chk("load_err", err, 0);
    trace.push_back(p);
    if (m == 0) begin
      for (int v = p + 1; v <= l; v++) trace.push_back(v);
      trace.push_back(l);
    end else if (m == 1) begin
      for (int v = p - 1; v >= l; v--) trace.push_back(v);
      trace.push_back(l);
    end else begin
      sw = (s == 0) ? 1 : s;
      for (int i = 0; i < sw; i++) begin
        for (int v = p + 1; v <= l; v++) trace.push_back(v);
        trace.push_back(l);
        for (int v = l - 1; v >= p; v--) trace.push_back(v);
        trace.push_back(p);
      end
    end
    d = trace.size();
    for (int k = 1; k <= d; k++) begin
      step();
      chk("q", q_cnt, trace[k-1]);
      chk("busy", busy, 1);
      chk("done", done, (k == d) ? 1 : 0);
      chk("load_low", load, 0);
      if (k == clr_k) begin
        clr = 1'b1;
        #1;
        chk("clr_busy", busy, 0);
        chk("clr_en", en, 0);
        chk("clr_load", load, 0);
        chk("clr_up_down", up_down, 1);
        chk("clr_data", data, 0);
        chk("clr_done", done, 0);
        chk("clr_q", q_cnt, 0);
        clr = 1'b0;
        $display("txn mode=%0d preset=%0d limit=%0d sweeps=%0d cleared at cycle %0d", m, p, l, s, k);
        step();
        chk("clr_idle", busy, 0);
        return;
      end
      if (k == abort_k) begin
        abort = 1'b1;
        #1;
        chk("abort_en", en, 0);
        chk("abort_load", load, 0);
        chk("abort_done", done, 0);
        step();
        abort = 1'b0;
        chk("abort_idle", busy, 0);
        chk("abort_hold", q_cnt, trace[k-1]);
        chk("abort_nodone", done, 0);
        $display("txn mode=%0d preset=%0d limit=%0d sweeps=%0d aborted at cycle %0d", m, p, l, s, k);
        return;
      end
      if (k < d) begin
        chk("en", en, (trace[k] != trace[k-1]) ? 1 : 0);
        if (trace[k] != trace[k-1]) chk("up_down", up_down, (trace[k] > trace[k-1]) ? 1 : 0);
      end else begin
        chk("done_en", en, 0);
      end
    end
    step();
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
    $display("txn mode=%0d preset=%0d limit=%0d sweeps=%0d done after edge %0d", m, p, l, s, d);
  endtask

  initial begin
    int m, p, l, s, ak, ck;
    clr = 1'b1; start = 1'b0; abort = 1'b0; mode = '0;
    preset = '0; limit = '0; sweeps = '0;
    step();
    step();
    clr = 1'b0;
    step();
    chk("rst_load", load, 0);
    chk("rst_en", en, 0);
    chk("rst_up_down", up_down, 1);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_q", q_cnt, 0);
    $display("txn reset checked");

    run_txn(0, 2, 5, 0, -1, -1);
    run_txn(1, 9, 3, 0, -1, -1);
    run_txn(2, 1, 3, 2, -1, -1);
    run_txn(0, 7, 4, 0, -1, -1);
    run_txn(3, 1, 8, 1, -1, -1);
    run_txn(1, 2, 6, 0, -1, -1);
    run_txn(2, 1, 3, 2, 2, -1);
    run_txn(2, 1, 3, 2, -1, 5);
    run_txn(0, 6, 6, 0, -1, -1);
    run_txn(2, 6, 6, 3, -1, -1);
    run_txn(2, 0, 15, 0, -1, -1);
    run_txn(0, 4, 9, 0, 6, -1);

    abort = 1'b1;
    step();
    chk("idle_abort_busy", busy, 0);
    abort = 1'b0;

    repeat (40) begin
      m  = $urandom_range(0, 3);
      p  = $urandom_range(0, 15);
      l  = $urandom_range(0, 15);
      s  = $urandom_range(0, 3);
      ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : -1;
      ck = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : -1;
      run_txn(m, p, l, s, ak, ck);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
